// File: rtl/hc_595_rx.sv
// hc_595_rx: receiving end of a chained 74HC595 serial display link.
// ds/shcp/stcp/oe are resynchronised onto sys_clk; shcp rising edges shift
// ds into a FRAME_BITS shift register, stcp rising edges check the number
// of bits shifted since the previous stcp and latch a full frame onto the
// parallel sel/seg outputs. oe (active-low) blanks sel/seg without losing
// the latched frame.
module hc_595_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = 6,
  parameter int SEG_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             ds,
  input  logic             shcp,
  input  logic             stcp,
  input  logic             oe,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             frame_vld,
  output logic             frame_err
);

  localparam int FRAME_BITS = SEL_W + SEG_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int ARM_W      = $clog2(SYNC_STAGES + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  // Synchronizer chains, all the same depth so ds stays aligned with shcp.
  logic [SYNC_STAGES-1:0] ds_pipe;
  logic [SYNC_STAGES-1:0] shcp_pipe;
  logic [SYNC_STAGES-1:0] stcp_pipe;
  logic [SYNC_STAGES-1:0] oe_pipe;

  logic ds_s;
  logic shcp_s;
  logic stcp_s;
  logic oe_s;

  logic shcp_hist;
  logic stcp_hist;

  logic [ARM_W-1:0] arm_cnt;
  logic             arm;

  logic                  shcp_rise;
  logic                  stcp_rise;

  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] sr_nxt;
  logic [CNT_W-1:0]      shift_cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      sel_nxt;
  logic [SEG_W-1:0]      seg_q;
  logic [SEG_W-1:0]      seg_nxt;
  logic                  vld_nxt;
  logic                  err_nxt;

  assign ds_s   = ds_pipe[SYNC_STAGES-1];
  assign shcp_s = shcp_pipe[SYNC_STAGES-1];
  assign stcp_s = stcp_pipe[SYNC_STAGES-1];
  assign oe_s   = oe_pipe[SYNC_STAGES-1];

  // Edges only count once the arm delay has let the chains and history
  // flops settle, so a pin held high through reset never looks like a rise.
  assign shcp_rise = arm & shcp_s & ~shcp_hist;
  assign stcp_rise = arm & stcp_s & ~stcp_hist;

  // Pin synchronizers and edge-history flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ds_pipe   <= '0;
      shcp_pipe <= '0;
      stcp_pipe <= '0;
      oe_pipe   <= '0;
      shcp_hist <= 1'b0;
      stcp_hist <= 1'b0;
    end else begin
      ds_pipe   <= {ds_pipe[SYNC_STAGES-2:0], ds};
      shcp_pipe <= {shcp_pipe[SYNC_STAGES-2:0], shcp};
      stcp_pipe <= {stcp_pipe[SYNC_STAGES-2:0], stcp};
      oe_pipe   <= {oe_pipe[SYNC_STAGES-2:0], oe};
      shcp_hist <= shcp_s;
      stcp_hist <= stcp_s;
    end
  end

  // Arm delay: SYNC_STAGES+1 cycles after reset release before edges count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      arm_cnt <= '0;
      arm     <= 1'b0;
    end else if (!arm) begin
      if (arm_cnt == ARM_LAST) begin
        arm <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
    end
  end

  // Next-state for shift register, bit count, latched frame and flags.
  // The latch decision uses the pre-shift register and count so that a
  // shcp rise coinciding with stcp belongs to the next frame.
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = shift_cnt;
    sel_nxt = sel_q;
    seg_nxt = seg_q;
    vld_nxt = 1'b0;
    err_nxt = 1'b0;
    if (stcp_rise) begin
      if (shift_cnt == CNT_FULL) begin
        sel_nxt = sr[SEL_W-1:0];
        for (int i = 0; i < SEG_W; i++) begin
          seg_nxt[SEG_W-1-i] = sr[SEL_W+i];
        end
        vld_nxt = 1'b1;
      end else if (shift_cnt != CNT_ZERO) begin
        err_nxt = 1'b1;
      end
      cnt_nxt = CNT_ZERO;
    end
    if (shcp_rise) begin
      sr_nxt = {ds_s, sr[FRAME_BITS-1:1]};
      if (stcp_rise) begin
        cnt_nxt = CNT_ONE;
      end else if (shift_cnt != CNT_SAT) begin
        cnt_nxt = shift_cnt + CNT_ONE;
      end
    end
  end

  // Frame state plus registered outputs; oe blanks the pins, not the frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr        <= '0;
      shift_cnt <= '0;
      sel_q     <= '0;
      seg_q     <= '0;
      sel       <= '0;
      seg       <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sr        <= sr_nxt;
      shift_cnt <= cnt_nxt;
      sel_q     <= sel_nxt;
      seg_q     <= seg_nxt;
      sel       <= oe_s ? '0 : sel_nxt;
      seg       <= oe_s ? '0 : seg_nxt;
      frame_vld <= vld_nxt;
      frame_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_hc_595_rx.sv
// Directed bench for hc_595_rx: serial frames driven at 2 high / 2 low
// sys_clk cycles per pin pulse, outputs sampled 1 ns after each rising edge.
module tb_hc_595_rx;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic       oe;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       frame_vld;
  logic       frame_err;

  int n_checks;
  int n_fail;
  int vld_cnt;
  int err_cnt;
  int both_cnt;
  int vld_base;
  int err_base;

  hc_595_rx #(
    .SYNC_STAGES(2),
    .SEL_W      (6),
    .SEG_W      (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .ds       (ds),
    .shcp     (shcp),
    .stcp     (stcp),
    .oe       (oe),
    .sel      (sel),
    .seg      (seg),
    .frame_vld(frame_vld),
    .frame_err(frame_err)
  );

  // Clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Flag pulse counters, sampled on the falling edge.
  initial begin
    vld_cnt  = 0;
    err_cnt  = 0;
    both_cnt = 0;
  end
  always @(negedge sys_clk) begin
    if (frame_vld) vld_cnt = vld_cnt + 1;
    if (frame_err) err_cnt = err_cnt + 1;
    if (frame_vld && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic shift_bit(input logic b);
    ds   = b;
    shcp = 1'b1;
    tick(2);
    shcp = 1'b0;
    tick(2);
  endtask

  task automatic pulse_stcp();
    stcp = 1'b1;
    tick(2);
    stcp = 1'b0;
    tick(2);
  endtask

  // Serial order: sel[0..5] then seg[7..0].
  function automatic logic [13:0] frame_bits(input logic [5:0] s, input logic [7:0] g);
    logic [13:0] b;
    b[5:0] = s;
    for (int i = 0; i < 8; i++) b[6+i] = g[7-i];
    return b;
  endfunction

  task automatic send_bits(input logic [13:0] b, input int first, input int last);
    for (int i = first; i <= last; i++) shift_bit(b[i]);
  endtask

  task automatic snap();
    vld_base = vld_cnt;
    err_base = err_cnt;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ds   = 1'($urandom_range(0, 1));
      shcp = i[0];
      stcp = ~i[1];
      oe   = 1'b0;
      tick(1);
    end
    n_checks++;
    if (sel !== 6'h00) begin n_fail++; $display("FAIL reset_sel: got %h exp 00", sel); end
    n_checks++;
    if (seg !== 8'h00) begin n_fail++; $display("FAIL reset_seg: got %h exp 00", seg); end
    n_checks++;
    if (frame_vld !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got vld=%b err=%b exp 0 0", frame_vld, frame_err);
    end
    // Pins held high across release must not produce a shift or a latch.
    shcp = 1'b1;
    stcp = 1'b1;
    ds   = 1'b1;
    tick(2);
    snap();
    sys_rst_n = 1'b1;
    tick(10);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(4);
    pulse_stcp();
    tick(3);
    n_checks++;
    if (err_cnt - err_base !== 0) begin
      n_fail++; $display("FAIL arm_no_shift: got err pulses %0d exp 0", err_cnt - err_base);
    end
    n_checks++;
    if (vld_cnt - vld_base !== 0) begin
      n_fail++; $display("FAIL arm_no_latch: got vld pulses %0d exp 0", vld_cnt - vld_base);
    end
    n_checks++;
    if (sel !== 6'h00 || seg !== 8'h00) begin
      n_fail++; $display("FAIL arm_outputs: got sel=%h seg=%h exp 00 00", sel, seg);
    end
  endtask

  task automatic test_good_frame();
    snap();
    send_bits(frame_bits(6'h3E, 8'hC0), 0, 13);
    stcp = 1'b1;
    tick(1);  // edge k
    tick(1);  // edge k+1
    n_checks++;
    if (sel !== 6'h00 || frame_vld !== 1'b0) begin
      n_fail++; $display("FAIL good_early: got sel=%h vld=%b exp 00 0", sel, frame_vld);
    end
    tick(1);  // edge k+2
    n_checks++;
    if (sel !== 6'h3E) begin n_fail++; $display("FAIL good_sel: got %h exp 3e", sel); end
    n_checks++;
    if (seg !== 8'hC0) begin n_fail++; $display("FAIL good_seg: got %h exp c0", seg); end
    n_checks++;
    if (frame_vld !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL good_flags: got vld=%b err=%b exp 1 0", frame_vld, frame_err);
    end
    tick(1);  // edge k+3
    n_checks++;
    if (frame_vld !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width: got vld=%b exp 0", frame_vld); end
    stcp = 1'b0;
    tick(4);
    n_checks++;
    if (vld_cnt - vld_base !== 1 || err_cnt - err_base !== 0) begin
      n_fail++; $display("FAIL good_counts: got vld=%0d err=%0d exp 1 0", vld_cnt - vld_base, err_cnt - err_base);
    end
  endtask

  task automatic test_bad_length();
    snap();
    send_bits(frame_bits(6'h15, 8'h5A), 0, 9);
    pulse_stcp();
    tick(2);
    n_checks++;
    if (err_cnt - err_base !== 1 || vld_cnt - vld_base !== 0) begin
      n_fail++; $display("FAIL short_flags: got err=%0d vld=%0d exp 1 0", err_cnt - err_base, vld_cnt - vld_base);
    end
    n_checks++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      n_fail++; $display("FAIL short_hold: got sel=%h seg=%h exp 3e c0", sel, seg);
    end
    // 16 shifts: count must saturate rather than wrap back to zero.
    snap();
    send_bits(frame_bits(6'h3F, 8'hFF), 0, 13);
    shift_bit(1'b1);
    shift_bit(1'b0);
    pulse_stcp();
    tick(2);
    n_checks++;
    if (err_cnt - err_base !== 1 || vld_cnt - vld_base !== 0) begin
      n_fail++; $display("FAIL long_flags: got err=%0d vld=%0d exp 1 0", err_cnt - err_base, vld_cnt - vld_base);
    end
    n_checks++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      n_fail++; $display("FAIL long_hold: got sel=%h seg=%h exp 3e c0", sel, seg);
    end
  endtask

  task automatic test_oe();
    snap();
    oe = 1'b1;
    tick(1);  // edge k
    tick(1);  // edge k+1
    n_checks++;
    if (sel !== 6'h3E) begin n_fail++; $display("FAIL oe_early: got sel=%h exp 3e", sel); end
    tick(1);  // edge k+2
    n_checks++;
    if (sel !== 6'h00 || seg !== 8'h00) begin
      n_fail++; $display("FAIL oe_blank: got sel=%h seg=%h exp 00 00", sel, seg);
    end
    tick(4);
    oe = 1'b0;
    tick(4);
    n_checks++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      n_fail++; $display("FAIL oe_restore: got sel=%h seg=%h exp 3e c0", sel, seg);
    end
    n_checks++;
    if (vld_cnt - vld_base !== 0 || err_cnt - err_base !== 0) begin
      n_fail++; $display("FAIL oe_flags: got vld=%0d err=%0d exp 0 0", vld_cnt - vld_base, err_cnt - err_base);
    end
  endtask

  task automatic test_stcp_after_reset();
    do_reset();
    snap();
    pulse_stcp();
    tick(2);
    n_checks++;
    if (vld_cnt - vld_base !== 0 || err_cnt - err_base !== 0) begin
      n_fail++; $display("FAIL zero_count_flags: got vld=%0d err=%0d exp 0 0", vld_cnt - vld_base, err_cnt - err_base);
    end
    n_checks++;
    if (sel !== 6'h00 || seg !== 8'h00) begin
      n_fail++; $display("FAIL zero_count_out: got sel=%h seg=%h exp 00 00", sel, seg);
    end
  endtask

  task automatic test_simultaneous();
    logic [13:0] bb;
    bb = frame_bits(6'h2A, 8'h81);
    snap();
    send_bits(frame_bits(6'h15, 8'hA5), 0, 13);
    ds   = bb[0];
    shcp = 1'b1;
    stcp = 1'b1;
    tick(2);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(4);
    n_checks++;
    if (sel !== 6'h15 || seg !== 8'hA5 || vld_cnt - vld_base !== 1) begin
      n_fail++; $display("FAIL simul_first: got sel=%h seg=%h vld=%0d exp 15 a5 1", sel, seg, vld_cnt - vld_base);
    end
    send_bits(bb, 1, 13);
    pulse_stcp();
    tick(2);
    n_checks++;
    if (sel !== 6'h2A || seg !== 8'h81 || vld_cnt - vld_base !== 2 || err_cnt - err_base !== 0) begin
      n_fail++; $display("FAIL simul_second: got sel=%h seg=%h vld=%0d err=%0d exp 2a 81 2 0",
                         sel, seg, vld_cnt - vld_base, err_cnt - err_base);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] s_tab [3];
    logic [7:0] g_tab [3];
    s_tab[0] = 6'h01; g_tab[0] = 8'h01;
    s_tab[1] = 6'h20; g_tab[1] = 8'h80;
    s_tab[2] = 6'h0C; g_tab[2] = 8'h3C;
    for (int f = 0; f < 3; f++) begin
      snap();
      send_bits(frame_bits(s_tab[f], g_tab[f]), 0, 13);
      pulse_stcp();
      tick(1);
      n_checks++;
      if (sel !== s_tab[f] || seg !== g_tab[f] || vld_cnt - vld_base !== 1 || err_cnt - err_base !== 0) begin
        n_fail++; $display("FAIL b2b_%0d: got sel=%h seg=%h vld=%0d err=%0d exp %h %h 1 0",
                           f, sel, seg, vld_cnt - vld_base, err_cnt - err_base, s_tab[f], g_tab[f]);
      end
    end
  endtask

  task automatic test_mid_reset();
    send_bits(frame_bits(6'h33, 8'h77), 0, 6);
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel !== 6'h00 || seg !== 8'h00) begin
      n_fail++; $display("FAIL midrst_async: got sel=%h seg=%h exp 00 00", sel, seg);
    end
    tick(2);
    sys_rst_n = 1'b1;
    tick(6);
    snap();
    pulse_stcp();
    tick(2);
    n_checks++;
    if (vld_cnt - vld_base !== 0 || err_cnt - err_base !== 0 || sel !== 6'h00) begin
      n_fail++; $display("FAIL midrst_discard: got vld=%0d err=%0d sel=%h exp 0 0 00",
                         vld_cnt - vld_base, err_cnt - err_base, sel);
    end
    snap();
    send_bits(frame_bits(6'h33, 8'h77), 0, 13);
    pulse_stcp();
    tick(2);
    n_checks++;
    if (sel !== 6'h33 || seg !== 8'h77 || vld_cnt - vld_base !== 1) begin
      n_fail++; $display("FAIL midrst_recover: got sel=%h seg=%h vld=%0d exp 33 77 1", sel, seg, vld_cnt - vld_base);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sys_rst_n = 1'b0;
    ds        = 1'b0;
    shcp      = 1'b0;
    stcp      = 1'b0;
    oe        = 1'b0;
    vld_base  = 0;
    err_base  = 0;
    test_reset();
    test_good_frame();
    test_bad_length();
    test_oe();
    test_stcp_after_reset();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL flags_exclusive: got %0d overlapping cycles exp 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
